// File: rtl/hilo_acc.sv
// hilo_acc: NCH independent HI/LO accumulator pairs with masked direct writes,
// a single-entry ADD/SUB commit stage, per-channel busy and sticky overflow.
module hilo_acc #(
    parameter int unsigned DW  = 32,
    parameter int unsigned NCH = 2,
    parameter int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [1:0]      wr_op,
    input  logic            wr_sgn,
    input  logic [CW-1:0]   wr_ch,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [DW-1:0]   hi_i,
    input  logic [DW-1:0]   lo_i,
    input  logic [CW-1:0]   rd_ch,
    output logic [DW-1:0]   hi_o,
    output logic [DW-1:0]   lo_o,
    output logic [NCH-1:0]  busy_o,
    output logic [NCH-1:0]  ovf_o
);

    localparam int unsigned AW = 2 * DW;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_ADD   = 2'b01,
        OP_SUB   = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    op_e             op;
    logic            accept;
    logic            wr_in_range;
    logic            stage_load;

    logic [DW-1:0]   hi_q [NCH];
    logic [DW-1:0]   lo_q [NCH];
    logic [NCH-1:0]  ovf_q;

    logic            stage_valid;
    logic            stage_sub;
    logic            stage_sgn;
    logic [CW-1:0]   stage_ch;
    logic [AW-1:0]   stage_opnd;

    logic [AW-1:0]   acc_cur;
    logic [AW:0]     sum_x;
    logic [AW-1:0]   acc_new;
    logic            signed_ovf;
    logic            ovf_hit;

    assign op          = op_e'(wr_op);
    assign wr_ready    = rst && !(stage_valid && (stage_ch == wr_ch));
    assign accept      = wr_valid && wr_ready;
    assign wr_in_range = (32'(wr_ch) < NCH);
    assign stage_load  = accept && wr_in_range && ((op == OP_ADD) || (op == OP_SUB));
    assign ovf_o       = ovf_q;

    // Pending accumulate stage: reloads on the same edge it commits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= 1'b0;
            stage_sub   <= 1'b0;
            stage_sgn   <= 1'b0;
            stage_ch    <= '0;
            stage_opnd  <= '0;
        end else if (stage_load) begin
            stage_valid <= 1'b1;
            stage_sub   <= (op == OP_SUB);
            stage_sgn   <= wr_sgn;
            stage_ch    <= wr_ch;
            stage_opnd  <= {hi_i, lo_i};
        end else begin
            stage_valid <= 1'b0;
        end
    end

    // Commit arithmetic for the staged channel, with carry/borrow and signed overflow
    always_comb begin
        acc_cur = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (stage_ch == CW'(c)) begin
                acc_cur = {hi_q[c], lo_q[c]};
            end
        end
        if (stage_sub) begin
            sum_x = {1'b0, acc_cur} - {1'b0, stage_opnd};
        end else begin
            sum_x = {1'b0, acc_cur} + {1'b0, stage_opnd};
        end
        acc_new    = sum_x[AW-1:0];
        signed_ovf = (stage_sub ? (acc_cur[AW-1] != stage_opnd[AW-1])
                                : (acc_cur[AW-1] == stage_opnd[AW-1]))
                     && (acc_new[AW-1] != acc_cur[AW-1]);
        ovf_hit    = stage_sgn ? signed_ovf : sum_x[AW];
    end

    // Per-channel storage: a commit and a WRITE never target the same channel,
    // because the hazard check stalls same-channel requests while staged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                hi_q[c] <= '0;
                lo_q[c] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (stage_valid && (stage_ch == CW'(c))) begin
                    hi_q[c] <= acc_new[AW-1:DW];
                    lo_q[c] <= acc_new[DW-1:0];
                    if (ovf_hit) begin
                        ovf_q[c] <= 1'b1;
                    end
                end else if (accept && (op == OP_WRITE) && (wr_ch == CW'(c))) begin
                    if (hi_we_i) begin
                        hi_q[c] <= hi_i;
                    end
                    if (lo_we_i) begin
                        lo_q[c] <= lo_i;
                    end
                    if (hi_we_i && lo_we_i) begin
                        ovf_q[c] <= 1'b0;
                    end
                end
            end
        end
    end

    // Read mux and busy flags; out-of-range read channel returns zero
    always_comb begin
        hi_o   = '0;
        lo_o   = '0;
        busy_o = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (rd_ch == CW'(c)) begin
                hi_o = hi_q[c];
                lo_o = lo_q[c];
            end
            busy_o[c] = stage_valid && (stage_ch == CW'(c));
        end
    end

endmodule
